ov7670_emulador: RTL and testbench
==================================

Name: ov7670_emulador

Overview:
Synthetic camera source that drives the OV7670-style parallel bus (vsync, href, 8-bit data) consumed by the capture/downsampler path. It emits complete frames of RGB565 pixels, high byte first, using programmable blanking. Each frame carries a selectable test pattern, so the capture, RGB332 conversion and DPRAM write path can be exercised in simulation and on the board without the physical camera. It sits in place of the camera, clocked by xclk, and feeds the capture block's data/href/vsync inputs directly.

Parameters:
IMG_W, 160, active pixels per line; must be a multiple of 8.
IMG_H, 120, active lines per frame.
HBLANK, 16, xclk cycles with href low after every active line.
VSYNC_CLKS, 8, xclk cycles with vsync high at frame start.
VBACK_CLKS, 16, xclk cycles with vsync and href low between the end of vsync and the first line.
VFRONT_CLKS, 16, xclk cycles with vsync and href low after the last line's HBLANK.

Ports:
xclk  in  1  bus clock; all outputs change only on its rising edge.
rst  in  1  asynchronous reset, active-low.
en  in  1  frame generation enable; sampled in IDLE and at the end of each frame.
pattern  in  2  test pattern select: 0 colour bars, 1 gradient, 2 solid colour, 3 same as 0.
color  in  16  RGB565 value for pattern 2; sampled on entry to VSYNC.
vsync  out  1  frame sync, high during the VSYNC state only.
href  out  1  high while active line bytes are on data.
data  out  8  pixel byte; RGB565 high byte [15:8] first, then low byte [7:0]; 0 whenever href is 0.
frame_done  out  1  one-cycle pulse on the last VFRONT cycle.
frame_cnt  out  8  completed frames, wraps 255→0.

Behaviour:
- Reset (rst=0, asynchronous) forces state IDLE and every counter to 0. It also forces vsync=0, href=0, data=0, frame_done=0 and frame_cnt=0. Asserting rst mid-frame aborts the frame immediately, with no frame_done pulse.
- All outputs are registered. The receiver samples them on the next xclk rising edge.
- State IDLE: all outputs low. If en=1 at an edge, the next state is VSYNC, so vsync=1 from the following cycle.
- State VSYNC: vsync=1 for VSYNC_CLKS cycles. pattern and color are latched on entry and held for the whole frame. Next state is VBACK.
- State VBACK: all outputs low for VBACK_CLKS cycles. Next state is LINE, with row=0.
- State LINE: href=1 for exactly 2*IMG_W cycles. A byte toggle selects the high byte (even cycles) or low byte (odd cycles). col increments after each low byte, from 0 to IMG_W-1. Next state is HBLANK.
- State HBLANK: href=0 and data=0 for HBLANK cycles.
  - If row < IMG_H-1: row increments, col resets to 0, next state is LINE.
  - Otherwise: next state is VFRONT.
- State VFRONT: all low for VFRONT_CLKS cycles. frame_done=1 on the final cycle, and frame_cnt increments on that same edge.
  - If en=1 at that edge, the next state is VSYNC (back-to-back frames).
  - Otherwise, the next state is IDLE.
- en=0 mid-frame does not truncate the frame. The frame completes, then the block goes to IDLE.
- Frame length = VSYNC_CLKS + VBACK_CLKS + IMG_H*(2*IMG_W+HBLANK) + VFRONT_CLKS. With defaults this is 8+16+120*336+16 = 40360 cycles.
- Pattern 0 (and 3), colour bars:
  - Bar index = col/(IMG_W/8), implemented with a bar-width counter (no divider).
  - Bar colours in order 0-7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Pattern 1, gradient: pixel = {col[4:0], row[5:0], col[4:0]^row[4:0]}, with each field truncated to its width.
- Pattern 2, solid colour: pixel = latched color for every pixel of the frame.
- A pattern or color change mid-frame takes effect at the next VSYNC entry only.
- Counter widths must hold IMG_W, IMG_H and the largest blanking parameter without overflow.

Test Plan:
1. rst=0 then release, en=0 for 100 cycles -> vsync=href=0, data=0, frame_cnt=0 throughout.
2. Defaults, en=1, pattern=2, color=F81F -> vsync high for exactly 8 cycles, and the first href rises 16 cycles after vsync falls. 120 href pulses, each 320 cycles long, with 16-cycle gaps. Byte pairs are F8,1F throughout. frame_done pulses once, 40360 cycles after vsync first rises. frame_cnt=1.
3. pattern=0 -> on line 0, pixel 0 = FF,FF; pixel 20 = FF,E0; pixel 140 = 00,00. Every line is identical.
4. pattern=1 -> row 3, col 5 gives bytes 28,66 (pixel 0x2866). data=0 whenever href=0.
5. en held 1 for 3 frames, color changed to 001F mid-frame 1 -> frames are contiguous with no IDLE cycle between them. Frame 1 stays F81F; frame 2 is 00,1F. frame_cnt reaches 3.
6. rst asserted at row 50, col 80 -> outputs go to 0 immediately, with no frame_done pulse. After release with en=1, a full frame restarts from vsync.

Source files
------------

// File: rtl/ov7670_emulador.sv
// Synthetic OV7670-style camera: emits RGB565 frames (high byte first) on vsync/href/data
// with programmable blanking and a per-frame test pattern latched at VSYNC entry.
module ov7670_emulador #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int HBLANK      = 16,
    parameter int VSYNC_CLKS  = 8,
    parameter int VBACK_CLKS  = 16,
    parameter int VFRONT_CLKS = 16
) (
    input  logic        xclk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [15:0] color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int BAR_W     = IMG_W / 8;
    localparam int MAX_A     = (HBLANK > VSYNC_CLKS) ? HBLANK : VSYNC_CLKS;
    localparam int MAX_B     = (VBACK_CLKS > VFRONT_CLKS) ? VBACK_CLKS : VFRONT_CLKS;
    localparam int MAX_BLANK = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_BLANK + 1);
    // Gradient slices col[4:0] and row[5:0], so keep at least that many bits.
    localparam int COL_W     = ($clog2(IMG_W + 1) > 5) ? $clog2(IMG_W + 1) : 5;
    localparam int ROW_W     = ($clog2(IMG_H + 1) > 6) ? $clog2(IMG_H + 1) : 6;
    localparam int BAR_CNT_W = $clog2(BAR_W + 1);

    localparam logic [CNT_W-1:0]     VS_LAST  = CNT_W'(VSYNC_CLKS - 1);
    localparam logic [CNT_W-1:0]     VB_LAST  = CNT_W'(VBACK_CLKS - 1);
    localparam logic [CNT_W-1:0]     HB_LAST  = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0]     VF_LAST  = CNT_W'(VFRONT_CLKS - 1);
    localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [BAR_CNT_W-1:0] BAR_LAST = BAR_CNT_W'(BAR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_LINE,
        S_HBLANK,
        S_VFRONT
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [COL_W-1:0]     r_col, w_col_nxt;
    logic [ROW_W-1:0]     r_row, w_row_nxt;
    logic                 r_byte, w_byte_nxt;
    logic [BAR_CNT_W-1:0] r_bar_cnt, w_bar_cnt_nxt;
    logic [2:0]           r_bar, w_bar_nxt;
    logic [1:0]           r_pat;
    logic [15:0]          r_color;
    logic                 r_vsync, r_href, r_frame_done;
    logic [7:0]           r_data, r_frame_cnt;
    logic                 w_frame_end, w_latch;
    logic [15:0]          w_bar_color, w_pixel;
    logic [7:0]           w_data_nxt;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_col_nxt     = r_col;
        w_row_nxt     = r_row;
        w_byte_nxt    = r_byte;
        w_bar_cnt_nxt = r_bar_cnt;
        w_bar_nxt     = r_bar;
        w_frame_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_VSYNC;
                    w_cnt_nxt   = '0;
                end
            end
            S_VSYNC: begin
                if (r_cnt == VS_LAST) begin
                    w_state_nxt = S_VBACK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_VBACK: begin
                if (r_cnt == VB_LAST) begin
                    w_state_nxt   = S_LINE;
                    w_cnt_nxt     = '0;
                    w_row_nxt     = '0;
                    w_col_nxt     = '0;
                    w_byte_nxt    = 1'b0;
                    w_bar_cnt_nxt = '0;
                    w_bar_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LINE: begin
                w_byte_nxt = ~r_byte;
                if (r_byte) begin
                    if (r_col == COL_LAST) begin
                        w_state_nxt = S_HBLANK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                        // Bar index advances every BAR_W pixels instead of dividing col.
                        if (r_bar_cnt == BAR_LAST) begin
                            w_bar_cnt_nxt = '0;
                            w_bar_nxt     = r_bar + 3'd1;
                        end else begin
                            w_bar_cnt_nxt = r_bar_cnt + BAR_CNT_W'(1);
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (r_cnt == HB_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_row < ROW_LAST) begin
                        w_state_nxt   = S_LINE;
                        w_row_nxt     = r_row + ROW_W'(1);
                        w_col_nxt     = '0;
                        w_byte_nxt    = 1'b0;
                        w_bar_cnt_nxt = '0;
                        w_bar_nxt     = '0;
                    end else begin
                        w_state_nxt = S_VFRONT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_VFRONT: begin
                if (r_cnt == VF_LAST) begin
                    w_frame_end = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = en ? S_VSYNC : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        w_bar_color = 16'h0000;
        case (w_bar_nxt)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
        case (r_pat)
            2'd1:    w_pixel = {w_col_nxt[4:0], w_row_nxt[5:0], w_col_nxt[4:0] ^ w_row_nxt[4:0]};
            2'd2:    w_pixel = r_color;
            default: w_pixel = w_bar_color;
        endcase
        w_data_nxt = 8'h00;
        if (w_state_nxt == S_LINE) begin
            w_data_nxt = w_byte_nxt ? w_pixel[7:0] : w_pixel[15:8];
        end
        w_latch = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);
    end

    always_ff @(posedge xclk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_byte       <= 1'b0;
            r_bar_cnt    <= '0;
            r_bar        <= '0;
            r_pat        <= '0;
            r_color      <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'h00;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values of the others.
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_byte       <= w_byte_nxt;
            r_bar_cnt    <= w_bar_cnt_nxt;
            r_bar        <= w_bar_nxt;
            r_vsync      <= (w_state_nxt == S_VSYNC);
            r_href       <= (w_state_nxt == S_LINE);
            r_data       <= w_data_nxt;
            r_frame_done <= (w_state_nxt == S_VFRONT) && (w_cnt_nxt == VF_LAST);
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_latch) begin
                r_pat   <= pattern;
                r_color <= color;
            end
        end
    end

    assign vsync      = r_vsync;
    assign href       = r_href;
    assign data       = r_data;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov7670_emulador.sv
// Bench for ov7670_emulador: a default-size instance for frame timing and patterns,
// and a small instance for back-to-back frames and latched pattern/colour changes.
module tb_ov7670_emulador;

    logic        clk = 1'b0;
    logic        rst_b, rst_s, sel;
    logic        en;
    logic [1:0]  pattern;
    logic [15:0] color;

    logic        b_vsync, b_href, b_frame_done, s_vsync, s_href, s_frame_done;
    logic [7:0]  b_data, b_frame_cnt, s_data, s_frame_cnt;
    logic        m_vsync, m_href, m_frame_done;
    logic [7:0]  m_data, m_frame_cnt;

    always #5 clk = ~clk;

    ov7670_emulador u_big (
        .xclk(clk), .rst(rst_b), .en(en), .pattern(pattern), .color(color),
        .vsync(b_vsync), .href(b_href), .data(b_data),
        .frame_done(b_frame_done), .frame_cnt(b_frame_cnt)
    );

    ov7670_emulador #(
        .IMG_W(16), .IMG_H(4), .HBLANK(4), .VSYNC_CLKS(2), .VBACK_CLKS(3), .VFRONT_CLKS(3)
    ) u_small (
        .xclk(clk), .rst(rst_s), .en(en), .pattern(pattern), .color(color),
        .vsync(s_vsync), .href(s_href), .data(s_data),
        .frame_done(s_frame_done), .frame_cnt(s_frame_cnt)
    );

    assign m_vsync      = sel ? s_vsync      : b_vsync;
    assign m_href       = sel ? s_href       : b_href;
    assign m_data       = sel ? s_data       : b_data;
    assign m_frame_done = sel ? s_frame_done : b_frame_done;
    assign m_frame_cnt  = sel ? s_frame_cnt  : b_frame_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int fd_n     = 0;
    int fd_cyc   = 0;
    int bad_data = 0;
    bit prev_vs  = 1'b0;
    int vs_rise[$];
    logic [7:0] cap [0:127][0:320];

    typedef struct {
        int         pat;
        int         row;
        int         col;
        logic [7:0] hi;
        logic [7:0] lo;
    } probe_t;
    probe_t probes [16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One sample per cycle on the falling edge; also tracks frame_done, vsync rises and data outside href.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (m_frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
        if (!m_href && m_data != 8'h00) bad_data++;
        if (m_vsync && !prev_vs) vs_rise.push_back(cyc);
        prev_vs = m_vsync;
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return m_vsync;
            default: return !m_vsync && !m_href;
        endcase
    endfunction

    task automatic run_len(input int kind, input int limit, output int n);
        n = 0;
        while (n <= limit && cond(kind)) begin
            n++;
            step();
        end
    endtask

    task automatic wait_vsync(input string tag, input int budget);
        for (int i = 0; i < budget && !m_vsync; i++) step();
        check({tag, " vsync_start"}, int'(m_vsync), 1);
    endtask

    // Called on the first vsync sample; captures rows [0, rows) and checks blanking lengths.
    task automatic cap_frame(input string tag, input int w, input int h, input int hb,
                             input int vs, input int vb, input int vf, input int rows);
        int n;
        int bad_len = 0;
        int bad_gap = 0;
        run_len(0, vs + 2, n);
        check({tag, " vsync_len"}, n, vs);
        run_len(1, vb + 2, n);
        check({tag, " vback_len"}, n, vb);
        for (int r = 0; r < rows; r++) begin
            n = 0;
            while (m_href && n <= 2 * w) begin
                cap[r][n] = m_data;
                n++;
                step();
            end
            if (n != 2 * w) bad_len++;
            if (r < h - 1) begin
                run_len(1, hb + 2, n);
                if (n != hb) bad_gap++;
            end else begin
                for (n = 1; n <= hb + vf + 2; n++) begin
                    if (m_frame_done) break;
                    step();
                end
                check({tag, " vfront_to_done"}, n, hb + vf);
            end
        end
        check({tag, " href_len_errs"}, bad_len, 0);
        check({tag, " hblank_errs"}, bad_gap, 0);
    endtask

    function automatic logic [15:0] exp_pix(input int pat, input logic [15:0] clr,
                                            input int row, input int col, input int w);
        logic [4:0] c5;
        logic [5:0] r6;
        int b;
        case (pat)
            2: return clr;
            1: begin
                c5 = col[4:0];
                r6 = row[5:0];
                return {c5, r6, c5 ^ row[4:0]};
            end
            default: begin
                b = col / (w / 8);
                case (b)
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
        endcase
    endfunction

    function automatic int pix_errs(input int pat, input logic [15:0] clr, input int rows, input int w);
        int e = 0;
        logic [15:0] p;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                p = exp_pix(pat, clr, r, c, w);
                if (cap[r][2 * c] !== p[15:8] || cap[r][2 * c + 1] !== p[7:0]) e++;
            end
        end
        return e;
    endfunction

    task automatic apply_probes(input int pat);
        for (int i = 0; i < 16; i++) begin
            if (probes[i].pat == pat) begin
                check($sformatf("probe%0d_hi", i), cap[probes[i].row][2 * probes[i].col], probes[i].hi);
                check($sformatf("probe%0d_lo", i), cap[probes[i].row][2 * probes[i].col + 1], probes[i].lo);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        int vs0;
        int fd_before;
        int fd_b0;

        probes[0]  = '{0,   0,   0, 8'hFF, 8'hFF};
        probes[1]  = '{0,   0,  20, 8'hFF, 8'hE0};
        probes[2]  = '{0,   0, 140, 8'h00, 8'h00};
        probes[3]  = '{0,   0,  19, 8'hFF, 8'hFF};
        probes[4]  = '{0,   0,  40, 8'h07, 8'hFF};
        probes[5]  = '{0,   0,  60, 8'h07, 8'hE0};
        probes[6]  = '{0,   0,  80, 8'hF8, 8'h1F};
        probes[7]  = '{0,   0, 100, 8'hF8, 8'h00};
        probes[8]  = '{0,  49, 120, 8'h00, 8'h1F};
        probes[9]  = '{0,  49, 159, 8'h00, 8'h00};
        probes[10] = '{1,   3,   5, 8'h28, 8'h66};
        probes[11] = '{1,   0,   0, 8'h00, 8'h00};
        probes[12] = '{1,   1,   1, 8'h08, 8'h20};
        probes[13] = '{1,   5,  31, 8'hF8, 8'hBA};
        probes[14] = '{1,   4, 159, 8'hF8, 8'h9B};
        probes[15] = '{1,   2,  32, 8'h00, 8'h42};

        sel = 1'b0; en = 1'b0; pattern = 2'd0; color = 16'h0000;
        rst_b = 1'b1; rst_s = 1'b1;
        #1;
        rst_b = 1'b0; rst_s = 1'b0;

        // Reset state, then idle with en low.
        repeat (3) step();
        check("reset_outputs", int'({m_vsync, m_href, m_data, m_frame_done, m_frame_cnt}), 0);
        #2 rst_b = 1'b1;
        nz = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_vsync || m_href || m_data != 8'h00 || m_frame_cnt != 8'h00) nz++;
        end
        check("idle_outputs_nonzero", nz, 0);

        // Solid colour frame, en dropped mid-frame: frame completes, then IDLE.
        pattern = 2'd2; color = 16'hF81F; en = 1'b1;
        wait_vsync("f_solid", 5);
        vs0 = cyc;
        en = 1'b0;
        cap_frame("f_solid", 160, 120, 16, 8, 16, 16, 120);
        check("f_solid pixel_errs", pix_errs(2, 16'hF81F, 120, 160), 0);
        check("f_solid frame_done_count", fd_n, 1);
        check("f_solid frame_len", fd_cyc - vs0 + 1, 40360);
        step();
        check("f_solid frame_cnt", m_frame_cnt, 1);
        nz = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (m_vsync || m_href) nz++;
        end
        check("idle_after_frame", nz, 0);

        // Colour bars on the first 50 lines, then abort at row 50, col 80.
        pattern = 2'd0; en = 1'b1;
        wait_vsync("f_bars", 5);
        cap_frame("f_bars", 160, 120, 16, 8, 16, 16, 50);
        check("f_bars pixel_errs", pix_errs(0, 16'h0000, 50, 160), 0);
        apply_probes(0);
        repeat (160) step();
        check("abort_mid_href", int'(m_href), 1);
        check("abort_mid_data", m_data, 8'hF8);
        fd_before = fd_n;
        #2 rst_b = 1'b0;
        #1;
        check("abort_outputs", int'({m_vsync, m_href, m_data, m_frame_done, m_frame_cnt}), 0);
        repeat (3) step();

        // Restart after reset with the gradient pattern.
        pattern = 2'd1; color = 16'h0000;
        #2 rst_b = 1'b1;
        wait_vsync("f_grad", 4);
        cap_frame("f_grad", 160, 120, 16, 8, 16, 16, 6);
        check("f_grad pixel_errs", pix_errs(1, 16'h0000, 6, 160), 0);
        apply_probes(1);
        check("abort_no_frame_done", fd_n, fd_before);

        // Small instance: three back-to-back frames with mid-frame colour/pattern changes.
        step();
        #2;
        rst_b = 1'b0;
        sel = 1'b1;
        prev_vs = 1'b0;
        vs_rise.delete();
        fd_b0 = fd_n;
        pattern = 2'd2; color = 16'hF81F; en = 1'b1;
        rst_s = 1'b1;
        check("b2b frame_cnt_start", m_frame_cnt, 0);
        wait_vsync("b2b1", 4);
        color = 16'h001F;
        cap_frame("b2b1", 16, 4, 4, 2, 3, 3, 4);
        check("b2b1 pixel_errs", pix_errs(2, 16'hF81F, 4, 16), 0);
        step();
        check("b2b2 contiguous", int'(m_vsync), 1);
        pattern = 2'd3;
        cap_frame("b2b2", 16, 4, 4, 2, 3, 3, 4);
        check("b2b2 pixel_errs", pix_errs(2, 16'h001F, 4, 16), 0);
        step();
        check("b2b3 contiguous", int'(m_vsync), 1);
        en = 1'b0;
        cap_frame("b2b3", 16, 4, 4, 2, 3, 3, 4);
        check("b2b3 pixel_errs", pix_errs(3, 16'h001F, 4, 16), 0);
        step();
        check("b2b frame_cnt_end", m_frame_cnt, 3);
        check("b2b frame_done_count", fd_n - fd_b0, 3);
        check("b2b vsync_rises", vs_rise.size(), 3);
        if (vs_rise.size() == 3) begin
            check("b2b period_1", vs_rise[1] - vs_rise[0], 152);
            check("b2b period_2", vs_rise[2] - vs_rise[1], 152);
        end
        repeat (5) step();
        check("b2b idle_after", int'(m_vsync), 0);

        check("data_zero_outside_href", bad_data, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
